game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter: DEATH_FRAMES, 12'd60, number of frame_tick pulses spent in DYING before OVER (range 1..4095).
REQ-002 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: frame_tick  input  1  one-cycle pulse once per video frame.
REQ-005 Port: btn_flap  input  1  debounced player button, level, high = pressed.
REQ-006 Port: crash  input  1  collision flag from the collision checker, level.
REQ-007 Port: pass  input  1  pipe-cleared flag from the collision checker, level, may stay high for several cycles.
REQ-008 Port: game_state  output  2  0 = IDLE, 1 = PLAY, 2 = DYING, 3 = OVER.
REQ-009 Port: run  output  1  motion enable for the bird and pipe movers, high only in PLAY.
REQ-010 Port: flap  output  1  one-cycle jump pulse to the bird mover.
REQ-011 Port: bird_reset  output  1  one-cycle pulse that re-initialises bird and pipe positions.
REQ-012 Port: score_bcd  output  16  current score, 4 BCD digits, [15:12] = thousands.
REQ-013 Port: best_bcd  output  16  best score, 4 BCD digits; present only when HIGH_SCORE_EN is defined.

Function
REQ-014 btn_rise SHALL be btn_flap & ~btn_d; pass_rise SHALL be pass & ~pass_d, where btn_d and pass_d are one-cycle registered copies of their inputs.
REQ-015 IDLE: run = 0. On btn_rise: go to PLAY, clear score_bcd to 0, and pulse bird_reset in the same cycle as the transition register update.
REQ-016 PLAY: run = 1. Each btn_rise SHALL produce exactly one flap pulse, registered, one cycle after the edge.
REQ-017 PLAY: each pass_rise SHALL increment score_bcd by 1 in decimal. Digit 9 wraps to 0 with carry. The score saturates at 9999 and no digit wraps past 9999.
REQ-018 PLAY: crash = 1 in any cycle SHALL cause a transition to DYING on the next edge and load the death counter with DEATH_FRAMES.
REQ-019 If crash and pass_rise occur in the same cycle, crash wins. The score is not incremented and no flap is issued.
REQ-020 DYING: run = 0. The death counter decrements on each frame_tick. On the frame_tick where the counter equals 1, the block goes to OVER. btn_flap, crash and pass are ignored.
REQ-021 OVER: run = 0 and score_bcd is held. btn_rise goes to IDLE. A second btn_rise is then needed to start a new game.
REQ-022 flap and bird_reset SHALL never be high outside PLAY and the IDLE->PLAY transition respectively. Neither pulse shall last more than 1 cycle.
REQ-023 All outputs SHALL be registered. Latency from an input event to its output effect is exactly 1 clk cycle, not counting the edge-detect register.

Reset
REQ-024 On rst = 1 at a clk edge: game_state = IDLE, run = 0, flap = 0, bird_reset = 0, score_bcd = 0, death counter = 0, pass_d = 0.
REQ-025 On rst, btn_d SHALL be set to 1, so a button held through reset does not start a game until it is released and pressed again.
REQ-026 rst asserted mid-game (any state) SHALL abort to IDLE on the same edge. rst has priority over every other input.
REQ-027 best_bcd is also cleared to 0 by rst.

Configuration
REQ-028 Macro HIGH_SCORE_EN.
- Defined: the best_bcd port and register exist. On entry to OVER, if score_bcd > best_bcd (BCD compare), best_bcd takes score_bcd. best_bcd is otherwise held, including across IDLE and new games.
- Undefined: the best_bcd port and register are absent, and all other behaviour is identical.

Verification
REQ-029 rst with btn_flap held high, then keep it high for 10 cycles -> game_state stays 0. Release then press -> game_state = 1 and bird_reset = 1 for exactly 1 cycle.
REQ-030 In PLAY, pass high for 5 cycles, 3 separate times -> score_bcd = 16'h0003. Score preset to 16'h0009 plus one pass_rise -> 16'h0010.
REQ-031 Score at 16'h9999 plus one pass_rise -> score_bcd stays 16'h9999.
REQ-032 crash and pass_rise in the same cycle with score 16'h0004 -> game_state = 2 next cycle, score stays 16'h0004, run = 0.
REQ-033 DEATH_FRAMES = 3, in DYING, 3 frame_ticks with button presses between them -> game_state = 3 after the third tick, no flap pulses. Then btn_rise -> game_state = 0.
REQ-034 HIGH_SCORE_EN defined: play to score 16'h0012 and die, then play to 16'h0007 and die -> best_bcd = 16'h0012 after both games. Then rst -> best_bcd = 0.

Source files
------------

// File: rtl/game_ctrl.sv
// Game sequencer for a flappy-style game: IDLE -> PLAY -> DYING -> OVER, with a BCD score.
// Define HIGH_SCORE_EN to add the best_bcd port and register.
module game_ctrl #(
  parameter logic [11:0] DEATH_FRAMES = 12'd60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn_flap,
  input  logic        crash,
  input  logic        pass,
  output logic [1:0]  game_state,
  output logic        run,
  output logic        flap,
  output logic        bird_reset,
  output logic [15:0] score_bcd
`ifdef HIGH_SCORE_EN
  ,
  output logic [15:0] best_bcd
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic        run_reg, run_next;
  logic        flap_reg, flap_next;
  logic        bird_reset_reg, bird_reset_next;
  logic [15:0] score_reg, score_next;
  logic [11:0] death_cnt_reg, death_cnt_next;
  logic        btn_d, pass_d;
  logic        btn_rise, pass_rise;
  logic [15:0] score_inc;
  logic [3:0]  carry;

  assign btn_rise  = btn_flap & ~btn_d;
  assign pass_rise = pass & ~pass_d;

  // Ripple-carry decimal increment; saturation at 9999 is handled where it is used.
  assign carry[0] = 1'b1;
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      logic [3:0] digit;
      assign digit = score_reg[4*gi +: 4];
      assign score_inc[4*gi +: 4] = carry[gi] ? ((digit == 4'd9) ? 4'd0 : digit + 4'd1) : digit;
      if (gi < 3) begin : g_carry
        assign carry[gi+1] = carry[gi] & (digit == 4'd9);
      end
    end
  endgenerate

`ifdef HIGH_SCORE_EN
  logic [15:0] best_reg, best_next;
  assign best_bcd = best_reg;
`endif

  always_comb begin
    state_next      = state_reg;
    flap_next       = 1'b0;
    bird_reset_next = 1'b0;
    score_next      = score_reg;
    death_cnt_next  = death_cnt_reg;
`ifdef HIGH_SCORE_EN
    best_next       = best_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (btn_rise) begin
          state_next      = PLAY;
          score_next      = 16'h0000;
          bird_reset_next = 1'b1;
        end
      end
      PLAY: begin
        // A crash suppresses both the flap and any same-cycle score increment.
        if (crash) begin
          state_next     = DYING;
          death_cnt_next = DEATH_FRAMES;
        end else begin
          flap_next = btn_rise;
          if (pass_rise && (score_reg != 16'h9999)) begin
            score_next = score_inc;
          end
        end
      end
      DYING: begin
        if (frame_tick) begin
          death_cnt_next = death_cnt_reg - 12'd1;
          if (death_cnt_reg == 12'd1) begin
            state_next = OVER;
`ifdef HIGH_SCORE_EN
            // Packed BCD digits order the same way as the binary value.
            if (score_reg > best_reg) begin
              best_next = score_reg;
            end
`endif
          end
        end
      end
      OVER: begin
        if (btn_rise) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    run_next = (state_next == PLAY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      run_reg        <= 1'b0;
      flap_reg       <= 1'b0;
      bird_reset_reg <= 1'b0;
      score_reg      <= 16'h0000;
      death_cnt_reg  <= 12'd0;
      pass_d         <= 1'b0;
      btn_d          <= 1'b1; // a button held through reset must be released first
`ifdef HIGH_SCORE_EN
      best_reg       <= 16'h0000;
`endif
    end else begin
      state_reg      <= state_next;
      run_reg        <= run_next;
      flap_reg       <= flap_next;
      bird_reset_reg <= bird_reset_next;
      score_reg      <= score_next;
      death_cnt_reg  <= death_cnt_next;
      pass_d         <= pass;
      btn_d          <= btn_flap;
`ifdef HIGH_SCORE_EN
      best_reg       <= best_next;
`endif
    end
  end

  assign game_state = state_reg;
  assign run        = run_reg;
  assign flap       = flap_reg;
  assign bird_reset = bird_reset_reg;
  assign score_bcd  = score_reg;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: integer-level game model checked every cycle, plus directed literal checks.
module tb_game_ctrl;
  localparam int DF = 3;

  logic        clk = 1'b0;
  logic        rst, frame_tick, btn_flap, crash, pass;
  logic [1:0]  game_state;
  logic        run, flap, bird_reset;
  logic [15:0] score_bcd;
`ifdef HIGH_SCORE_EN
  logic [15:0] best_bcd;
`endif

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  int m_state, m_score, m_cnt, m_best;
  bit m_btn_d, m_pass_d, m_flap, m_bres;

  game_ctrl #(.DEATH_FRAMES(12'd3)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .btn_flap(btn_flap),
    .crash(crash), .pass(pass), .game_state(game_state), .run(run),
    .flap(flap), .bird_reset(bird_reset), .score_bcd(score_bcd)
`ifdef HIGH_SCORE_EN
    , .best_bcd(best_bcd)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Game rules expressed on integers: decimal score, frame countdown, best-so-far.
  always @(posedge clk) begin
    if (rst) begin
      m_state <= 0; m_score <= 0; m_cnt <= 0; m_best <= 0;
      m_btn_d <= 1'b1; m_pass_d <= 1'b0; m_flap <= 1'b0; m_bres <= 1'b0;
    end else begin
      m_btn_d  <= btn_flap;
      m_pass_d <= pass;
      m_flap   <= 1'b0;
      m_bres   <= 1'b0;
      case (m_state)
        0: if (btn_flap && !m_btn_d) begin
             m_state <= 1; m_score <= 0; m_bres <= 1'b1;
           end
        1: if (crash) begin
             m_state <= 2; m_cnt <= DF;
           end else begin
             if (btn_flap && !m_btn_d) m_flap <= 1'b1;
             if (pass && !m_pass_d) m_score <= (m_score < 9999) ? m_score + 1 : 9999;
           end
        2: if (frame_tick) begin
             m_cnt <= m_cnt - 1;
             if (m_cnt == 1) begin
               m_state <= 3;
               if (m_score > m_best) m_best <= m_score;
             end
           end
        default: if (btn_flap && !m_btn_d) m_state <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("state", 16'(game_state), 16'(m_state));
      chk("run", 16'(run), 16'(m_state == 1));
      chk("flap", 16'(flap), 16'(m_flap));
      chk("bird_reset", 16'(bird_reset), 16'(m_bres));
      chk("score", score_bcd, to_bcd(m_score));
`ifdef HIGH_SCORE_EN
      chk("best", best_bcd, to_bcd(m_best));
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pass_pulse(input int hi);
    pass = 1'b1; cyc(hi);
    pass = 1'b0; cyc(1);
  endtask

  task automatic start_game();
    btn_flap = 1'b0; cyc(1);
    btn_flap = 1'b1; cyc(1);
    chk("lit_start_state", 16'(game_state), 16'd1);
    btn_flap = 1'b0; cyc(1);
  endtask

  task automatic die_and_count(input bit presses);
    crash = 1'b1; cyc(1);
    crash = 1'b0;
    chk("lit_dying_state", 16'(game_state), 16'd2);
    for (int i = 0; i < DF; i++) begin
      frame_tick = 1'b1; cyc(1);
      frame_tick = 1'b0;
      chk("lit_tick_state", 16'(game_state), (i < DF - 1) ? 16'd2 : 16'd3);
      if (presses && i < DF - 1) begin
        btn_flap = 1'b1; cyc(1);
        btn_flap = 1'b0; cyc(1);
      end
    end
  endtask

  task automatic leave_over();
    btn_flap = 1'b1; cyc(1);
    chk("lit_over_to_idle", 16'(game_state), 16'd0);
    btn_flap = 1'b0; cyc(1);
  endtask

  initial begin
    rst = 1'b1; btn_flap = 1'b1; frame_tick = 1'b0; crash = 1'b0; pass = 1'b0;
    cyc(3);
    cmp_en = 1'b1;
    chk("lit_reset_score", score_bcd, 16'h0000);
    rst = 1'b0;
    cyc(10);
    chk("lit_held_btn_idle", 16'(game_state), 16'd0);

    btn_flap = 1'b0; cyc(1);
    btn_flap = 1'b1; cyc(1);
    chk("lit_play", 16'(game_state), 16'd1);
    chk("lit_bird_reset_hi", 16'(bird_reset), 16'd1);
    cyc(1);
    chk("lit_bird_reset_lo", 16'(bird_reset), 16'd0);
    btn_flap = 1'b0; cyc(1);

    btn_flap = 1'b1; cyc(1);
    chk("lit_flap_hi", 16'(flap), 16'd1);
    btn_flap = 1'b0; cyc(1);
    chk("lit_flap_lo", 16'(flap), 16'd0);

    repeat (3) pass_pulse(5);
    chk("lit_score3", score_bcd, 16'h0003);
    pass_pulse(1);
    chk("lit_score4", score_bcd, 16'h0004);

    crash = 1'b1; pass = 1'b1; cyc(1);
    crash = 1'b0; pass = 1'b0;
    chk("lit_crash_state", 16'(game_state), 16'd2);
    chk("lit_crash_score", score_bcd, 16'h0004);
    chk("lit_crash_run", 16'(run), 16'd0);
    for (int i = 0; i < DF; i++) begin
      frame_tick = 1'b1; cyc(1);
      frame_tick = 1'b0;
      chk("lit_tick_state", 16'(game_state), (i < DF - 1) ? 16'd2 : 16'd3);
      if (i < DF - 1) begin
        btn_flap = 1'b1; cyc(1);
        chk("lit_no_flap_dying", 16'(flap), 16'd0);
        btn_flap = 1'b0; cyc(1);
      end
    end
    chk("lit_over_score", score_bcd, 16'h0004);
    leave_over();

    start_game();
    repeat (9) pass_pulse(1);
    chk("lit_score9", score_bcd, 16'h0009);
    pass_pulse(1);
    chk("lit_score10", score_bcd, 16'h0010);
    repeat (2) pass_pulse(1);
    chk("lit_score12", score_bcd, 16'h0012);
    die_and_count(1'b0);
`ifdef HIGH_SCORE_EN
    chk("lit_best12", best_bcd, 16'h0012);
`endif
    leave_over();

    start_game();
    chk("lit_new_game_score", score_bcd, 16'h0000);
    repeat (7) pass_pulse(1);
    chk("lit_score7", score_bcd, 16'h0007);
    die_and_count(1'b1);
`ifdef HIGH_SCORE_EN
    chk("lit_best_kept", best_bcd, 16'h0012);
`endif
    leave_over();

    start_game();
    repeat (9999) pass_pulse(1);
    chk("lit_score9999", score_bcd, 16'h9999);
    pass_pulse(1);
    chk("lit_score_sat", score_bcd, 16'h9999);

    rst = 1'b1; cyc(1);
    chk("lit_rst_state", 16'(game_state), 16'd0);
    chk("lit_rst_score", score_bcd, 16'h0000);
    chk("lit_rst_run", 16'(run), 16'd0);
`ifdef HIGH_SCORE_EN
    chk("lit_rst_best", best_bcd, 16'h0000);
`endif
    rst = 1'b0; cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
